sys_ctrl: RTL and testbench

SYS_CTRL -- requirements
Module: sys_ctrl

---
 rtl/sys_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_sys_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// Frame-level command controller: decodes UART command frames into register-file
// writes/reads and ALU operations, and returns results to the TX FIFO.
module sys_ctrl #(
    parameter int data_width    = 8,
    parameter int address_width = 4,
    parameter int alu_fun_width = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [data_width-1:0]     RX_P_DATA,
    input  logic                      RX_D_VLD,
    input  logic [2*data_width-1:0]   ALU_OUT,
    input  logic                      ALU_OUT_VALID,
    input  logic [data_width-1:0]     RD_DATA,
    input  logic                      RD_DATA_VALID,
    input  logic                      FIFO_FULL,
    output logic                      ALU_EN,
    output logic [alu_fun_width-1:0]  ALU_FUN,
    output logic                      CLK_EN,
    output logic [address_width-1:0]  ADDRESS,
    output logic                      WR_EN,
    output logic                      RD_EN,
    output logic [data_width-1:0]     WR_DATA,
    output logic [data_width-1:0]     TX_P_DATA,
    output logic                      TX_D_VLD,
    output logic [3:0]                fsm_state
);

    // Handshakes: RX_D_VLD, RD_DATA_VALID and ALU_OUT_VALID are one-cycle pulses
    // with no back-pressure; TX_D_VLD is a write strobe qualified by !FIFO_FULL,
    // and TX_P_DATA holds its value for as long as the FIFO stays full.

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_ALU_A,
        S_ALU_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_TX_LSB,
        S_TX_MSB,
        S_TX_RD
    } state_t;

    localparam logic [data_width-1:0] CMD_WR     = data_width'(8'hAA);
    localparam logic [data_width-1:0] CMD_RD     = data_width'(8'hBB);
    localparam logic [data_width-1:0] CMD_ALU_OP = data_width'(8'hCC);
    localparam logic [data_width-1:0] CMD_ALU_NP = data_width'(8'hDD);

    state_t                     state, state_n;
    logic [address_width-1:0]   address_r, address_n;
    logic [data_width-1:0]      wr_data_r, wr_data_n;
    logic                       wr_en_r, wr_en_n;
    logic                       rd_en_r, rd_en_n;
    logic                       alu_en_r, alu_en_n;
    logic [alu_fun_width-1:0]   alu_fun_r, alu_fun_n;
    logic                       clk_en_r, clk_en_n;
    logic [data_width-1:0]      tx_data_r, tx_data_n;
    logic [data_width-1:0]      alu_msb_r, alu_msb_n;
    logic                       tx_active;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            address_r <= '0;
            wr_data_r <= '0;
            wr_en_r   <= 1'b0;
            rd_en_r   <= 1'b0;
            alu_en_r  <= 1'b0;
            alu_fun_r <= '0;
            clk_en_r  <= 1'b0;
            tx_data_r <= '0;
            alu_msb_r <= '0;
        end else begin
            state     <= state_n;
            address_r <= address_n;
            wr_data_r <= wr_data_n;
            wr_en_r   <= wr_en_n;
            rd_en_r   <= rd_en_n;
            alu_en_r  <= alu_en_n;
            alu_fun_r <= alu_fun_n;
            clk_en_r  <= clk_en_n;
            tx_data_r <= tx_data_n;
            alu_msb_r <= alu_msb_n;
        end
    end

    always_comb begin
        state_n   = state;
        address_n = address_r;
        wr_data_n = wr_data_r;
        wr_en_n   = 1'b0;
        rd_en_n   = 1'b0;
        alu_en_n  = 1'b0;
        alu_fun_n = alu_fun_r;
        clk_en_n  = 1'b0;
        tx_data_n = tx_data_r;
        alu_msb_n = alu_msb_r;
        case (state)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:     state_n = S_WR_ADDR;
                        CMD_RD:     state_n = S_RD_ADDR;
                        CMD_ALU_OP: state_n = S_ALU_A;
                        CMD_ALU_NP: state_n = S_ALU_FUN;
                        default:    state_n = S_IDLE;
                    endcase
                end
            end
            S_WR_ADDR: begin
                if (RX_D_VLD) begin
                    address_n = RX_P_DATA[address_width-1:0];
                    state_n   = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_n = RX_P_DATA;
                    wr_en_n   = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    address_n = RX_P_DATA[address_width-1:0];
                    rd_en_n   = 1'b1;
                    state_n   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (RD_DATA_VALID) begin
                    tx_data_n = RD_DATA;
                    state_n   = S_TX_RD;
                end
            end
            // Operands land in registers 0 and 1, where the ALU reads them.
            S_ALU_A: begin
                if (RX_D_VLD) begin
                    address_n = '0;
                    wr_data_n = RX_P_DATA;
                    wr_en_n   = 1'b1;
                    state_n   = S_ALU_B;
                end
            end
            S_ALU_B: begin
                if (RX_D_VLD) begin
                    address_n = address_width'(1);
                    wr_data_n = RX_P_DATA;
                    wr_en_n   = 1'b1;
                    state_n   = S_ALU_FUN;
                end
            end
            S_ALU_FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_n = RX_P_DATA[alu_fun_width-1:0];
                    alu_en_n  = 1'b1;
                    clk_en_n  = 1'b1;
                    state_n   = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                if (ALU_OUT_VALID) begin
                    tx_data_n = ALU_OUT[data_width-1:0];
                    alu_msb_n = ALU_OUT[2*data_width-1:data_width];
                    state_n   = S_TX_LSB;
                end else begin
                    clk_en_n  = 1'b1;
                end
            end
            S_TX_LSB: begin
                if (!FIFO_FULL) begin
                    tx_data_n = alu_msb_r;
                    state_n   = S_TX_MSB;
                end
            end
            S_TX_MSB, S_TX_RD: begin
                if (!FIFO_FULL) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // The strobe is combinational so a FIFO that fills this cycle is never written.
    assign tx_active = (state == S_TX_LSB) || (state == S_TX_MSB) || (state == S_TX_RD);
    assign TX_D_VLD  = tx_active && !FIFO_FULL;
    assign TX_P_DATA = tx_data_r;
    assign ADDRESS   = address_r;
    assign WR_DATA   = wr_data_r;
    assign WR_EN     = wr_en_r;
    assign RD_EN     = rd_en_r;
    assign ALU_EN    = alu_en_r;
    assign ALU_FUN   = alu_fun_r;
    assign CLK_EN    = clk_en_r;
    assign fsm_state = state;

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: directed frames, then random frames, checked against a
// transaction-level model of expected register accesses, ALU starts and TX bytes.
module tb_sys_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FW = 4;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [DW-1:0]   RX_P_DATA = '0;
    logic            RX_D_VLD = 1'b0;
    logic [2*DW-1:0] ALU_OUT = '0;
    logic            ALU_OUT_VALID = 1'b0;
    logic [DW-1:0]   RD_DATA = '0;
    logic            RD_DATA_VALID = 1'b0;
    logic            FIFO_FULL = 1'b0;
    logic            ALU_EN;
    logic [FW-1:0]   ALU_FUN;
    logic            CLK_EN;
    logic [AW-1:0]   ADDRESS;
    logic            WR_EN;
    logic            RD_EN;
    logic [DW-1:0]   WR_DATA;
    logic [DW-1:0]   TX_P_DATA;
    logic            TX_D_VLD;
    logic [3:0]      fsm_state;

    sys_ctrl #(.data_width(DW), .address_width(AW), .alu_fun_width(FW)) dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
        .RD_DATA(RD_DATA), .RD_DATA_VALID(RD_DATA_VALID),
        .FIFO_FULL(FIFO_FULL),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
        .ADDRESS(ADDRESS), .WR_EN(WR_EN), .RD_EN(RD_EN), .WR_DATA(WR_DATA),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW+DW-1:0] exp_wr_q[$];
    logic [AW-1:0]    exp_rd_q[$];
    logic [FW-1:0]    exp_alu_q[$];
    logic [DW-1:0]    exp_tx_q[$];
    logic [DW-1:0]    mem [2**AW];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            default: return {a, b} ^ {12'h0, f};
        endcase
    endfunction

    // Scoreboard: every strobe must match the head of its expected queue.
    logic [AW+DW-1:0] m_wr;
    always @(negedge CLK) begin
        if ((WR_EN | RD_EN | ALU_EN | TX_D_VLD) === 1'b1)
            chk("strobe_mutex", 16'($countones({WR_EN, RD_EN, ALU_EN, TX_D_VLD})), 16'd1);
        if (WR_EN === 1'b1) begin
            if (exp_wr_q.size() == 0) chk("wr_extra_pulse", 16'(exp_wr_q.size()), 16'd1);
            else begin
                m_wr = exp_wr_q.pop_front();
                chk("wr_addr_data", 16'({ADDRESS, WR_DATA}), 16'(m_wr));
            end
        end
        if (RD_EN === 1'b1) begin
            if (exp_rd_q.size() == 0) chk("rd_extra_pulse", 16'(exp_rd_q.size()), 16'd1);
            else chk("rd_addr", 16'(ADDRESS), 16'(exp_rd_q.pop_front()));
        end
        if (ALU_EN === 1'b1) begin
            if (exp_alu_q.size() == 0) chk("alu_extra_pulse", 16'(exp_alu_q.size()), 16'd1);
            else begin
                chk("alu_fun", 16'(ALU_FUN), 16'(exp_alu_q.pop_front()));
                chk("clk_en_at_alu_en", 16'(CLK_EN), 16'd1);
            end
        end
        if (TX_D_VLD === 1'b1) begin
            if (exp_tx_q.size() == 0) chk("tx_extra_pulse", 16'(exp_tx_q.size()), 16'd1);
            else chk("tx_byte", 16'(TX_P_DATA), 16'(exp_tx_q.pop_front()));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge CLK);
    endtask

    task automatic rd_resp(input logic [7:0] d);
        @(posedge CLK); #1;
        RD_DATA       = d;
        RD_DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        RD_DATA_VALID = 1'b0;
    endtask

    task automatic alu_resp(input logic [15:0] r);
        @(posedge CLK); #1;
        ALU_OUT       = r;
        ALU_OUT_VALID = 1'b1;
        @(posedge CLK); #1;
        ALU_OUT_VALID = 1'b0;
    endtask

    task automatic drain(input bit rand_full);
        int i;
        i = 0;
        while ((exp_wr_q.size() + exp_rd_q.size() + exp_alu_q.size() + exp_tx_q.size()) != 0
               && i < 200) begin
            @(posedge CLK); #1;
            FIFO_FULL = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
            i++;
        end
        FIFO_FULL = 1'b0;
        if (i >= 200) chk("drain_timeout", 16'(exp_tx_q.size() + exp_wr_q.size()), 16'd0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic junk_byte();
        if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 255)));
    endtask

    task automatic do_write(input logic [7:0] ab, input logic [7:0] d, input bit rf);
        exp_wr_q.push_back({ab[AW-1:0], d});
        mem[ab[AW-1:0]] = d;
        send_byte(8'hAA); send_byte(ab); send_byte(d);
        drain(rf);
    endtask

    task automatic do_read(input logic [7:0] ab, input bit rf);
        exp_rd_q.push_back(ab[AW-1:0]);
        exp_tx_q.push_back(mem[ab[AW-1:0]]);
        send_byte(8'hBB); send_byte(ab);
        if (rf) junk_byte();
        rd_resp(mem[ab[AW-1:0]]);
        drain(rf);
    endtask

    task automatic do_alu_tail(input logic [7:0] fb, input bit rf);
        logic [15:0] r;
        r = alu_model(mem[0], mem[1], fb[FW-1:0]);
        exp_alu_q.push_back(fb[FW-1:0]);
        exp_tx_q.push_back(r[7:0]);
        exp_tx_q.push_back(r[15:8]);
        send_byte(fb);
        if (rf) junk_byte();
        alu_resp(r);
        drain(rf);
    endtask

    task automatic do_alu_cc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] fb,
                             input bit rf);
        exp_wr_q.push_back({AW'(0), a});
        exp_wr_q.push_back({AW'(1), b});
        mem[0] = a;
        mem[1] = b;
        send_byte(8'hCC); send_byte(a); send_byte(b);
        do_alu_tail(fb, rf);
    endtask

    initial begin
        logic [15:0] r;
        logic [7:0]  b;
        for (int i = 0; i < 2**AW; i++) mem[i] = 8'($urandom_range(0, 255));

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_strobes", 16'({WR_EN, RD_EN, ALU_EN, TX_D_VLD, CLK_EN}), 16'd0);
        chk("rst_addr_fun", 16'({ADDRESS, ALU_FUN}), 16'd0);
        chk("rst_wr_data", 16'(WR_DATA), 16'd0);
        chk("rst_tx_data", 16'(TX_P_DATA), 16'd0);

        do_write(8'h09, 8'hA6, 1'b0);
        do_read(8'h09, 1'b0);
        do_alu_cc(8'h35, 8'h88, 8'h02, 1'b0);

        // ALU without operands, with the FIFO held full across the result.
        r = alu_model(mem[0], mem[1], 4'h8);
        exp_alu_q.push_back(4'h8);
        exp_tx_q.push_back(r[7:0]);
        exp_tx_q.push_back(r[15:8]);
        send_byte(8'hDD);
        send_byte(8'h08);
        @(negedge CLK);
        chk("clk_en_waiting", 16'(CLK_EN), 16'd1);
        FIFO_FULL = 1'b1;
        alu_resp(r);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("tx_held_low", 16'(TX_D_VLD), 16'd0);
            chk("tx_data_stable", 16'(TX_P_DATA), 16'(r[7:0]));
            chk("clk_en_after_result", 16'(CLK_EN), 16'd0);
        end
        drain(1'b0);

        send_byte(8'h55);
        repeat (3) begin
            @(negedge CLK);
            chk("unknown_cmd_quiet", 16'({WR_EN, RD_EN, ALU_EN, TX_D_VLD, CLK_EN}), 16'd0);
        end

        // Reset in the middle of a CC frame: operand A write happens, nothing after.
        exp_wr_q.push_back({AW'(0), 8'h35});
        mem[0] = 8'h35;
        send_byte(8'hCC);
        send_byte(8'h35);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("midrst_strobes", 16'({WR_EN, RD_EN, ALU_EN, TX_D_VLD, CLK_EN}), 16'd0);
        chk("midrst_wr_data", 16'(WR_DATA), 16'd0);
        do_write(8'h03, 8'h11, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: do_write(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
                1: do_read(8'($urandom_range(0, 255)), 1'b1);
                2: do_alu_cc(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                             8'($urandom_range(0, 255)), 1'b1);
                3: begin
                    send_byte(8'hDD);
                    do_alu_tail(8'($urandom_range(0, 255)), 1'b1);
                end
                default: begin
                    b = 8'($urandom_range(0, 255));
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD)
                        b = 8'($urandom_range(0, 255));
                    send_byte(b);
                    drain(1'b1);
                end
            endcase
        end

        repeat (5) @(posedge CLK);
        #1;
        chk("left_wr", 16'(exp_wr_q.size()), 16'd0);
        chk("left_rd", 16'(exp_rd_q.size()), 16'd0);
        chk("left_alu", 16'(exp_alu_q.size()), 16'd0);
        chk("left_tx", 16'(exp_tx_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
